// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM pipeline stage: ALU op codes, reset level and
// the per-instruction bundle captured while a memory access is outstanding.
package mem_access_unit_pkg;

    localparam logic RST_ENABLE  = 1'b0;
    localparam logic RST_DISABLE = 1'b1;

    localparam int unsigned ALUOP_W    = 4;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 4'h0;
    localparam logic [ALUOP_W-1:0] EXE_ADD_OP = 4'h1;
    localparam logic [ALUOP_W-1:0] EXE_SUB_OP = 4'h2;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP = 4'h3;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP  = 4'h4;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP = 4'h5;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP = 4'h6;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP = 4'h7;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP = 4'h8;
    localparam logic [ALUOP_W-1:0] EXE_LUI_OP = 4'h9;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 4'hA;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 4'hB;

    // Writeback-side fields held while the memory transaction is in flight.
    typedef struct packed {
        logic                  is_load;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
    } mem_op_t;

    function automatic logic is_mem_op(input logic [ALUOP_W-1:0] op);
        return (op == EXE_LW_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/mem_access_unit_timeout_ctr.sv
// Bounds how long the MEM stage waits for a data-memory acknowledge.
module mem_timeout_ctr
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: runs load/store req/ack transactions against data memory
// and registers the writeback bundle for every accepted instruction.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     store_data_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_W-3:0]     dmem_addr_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic                  wb_valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  err_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e  state_q, state_d;
    mem_op_t op_q, op_d;

    logic                  stall_c;
    logic                  cnt_clr, cnt_en, timeout_hit;
    logic                  is_mem, misaligned;

    logic                  req_d, we_d;
    logic [ADDR_W-3:0]     daddr_d;
    logic [DATA_W-1:0]     dwdata_d;
    logic                  wb_valid_d, wreg_d, err_d;
    logic [REG_ADDR_W-1:0] wd_d;
    logic [DATA_W-1:0]     wdata_d;

    assign is_mem     = is_mem_op(aluop_i);
    assign misaligned = (mem_addr_i[1:0] != 2'b00);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .hit_c (timeout_hit)
    );

    // Stall is combinational so upstream holds in the very cycle of acceptance.
    assign stall_o = (rst != RST_ENABLE) && stall_c;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            wb_valid_o   <= 1'b0;
            wd_o         <= '0;
            wreg_o       <= 1'b0;
            wdata_o      <= '0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            dmem_req_o   <= req_d;
            dmem_we_o    <= we_d;
            dmem_addr_o  <= daddr_d;
            dmem_wdata_o <= dwdata_d;
            wb_valid_o   <= wb_valid_d;
            wd_o         <= wd_d;
            wreg_o       <= wreg_d;
            wdata_o      <= wdata_d;
            err_o        <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        stall_c    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        req_d      = dmem_req_o;
        we_d       = dmem_we_o;
        daddr_d    = dmem_addr_o;
        dwdata_d   = dmem_wdata_o;
        wb_valid_d = 1'b0;
        wreg_d     = 1'b0;
        wd_d       = wd_o;
        wdata_d    = wdata_o;
        err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wd_d       = wd_i;
                        wreg_d     = wreg_i;
                        wdata_d    = wdata_i;
                    end else if (misaligned) begin
                        wb_valid_d = 1'b1;
                        wd_d       = wd_i;
                        err_d      = 1'b1;
                    end else begin
                        stall_c      = 1'b1;
                        state_d      = ST_BUSY;
                        op_d.is_load = (aluop_i == EXE_LW_OP);
                        op_d.wd      = wd_i;
                        op_d.wreg    = wreg_i;
                        req_d        = 1'b1;
                        we_d         = (aluop_i == EXE_SW_OP);
                        daddr_d      = mem_addr_i[ADDR_W-1:2];
                        dwdata_d     = store_data_i;
                    end
                end
            end

            ST_BUSY: begin
                // Ack takes priority over a coincident timeout.
                if (dmem_ack_i) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wd_d       = op_q.wd;
                    if (op_q.is_load) begin
                        wreg_d  = op_q.wreg;
                        wdata_d = dmem_rdata_i;
                    end
                end else if (timeout_hit) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wd_d       = op_q.wd;
                    err_d      = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    cnt_en  = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected writeback
// bundles, a negedge monitor pops and compares each wb_valid_o pulse.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [3:0]        aluop_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] store_data_i;
    logic [4:0]        wd_i;
    logic              wreg_i;
    logic [DATA_W-1:0] wdata_i;
    logic              stall_o;
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [ADDR_W-3:0] dmem_addr_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic              dmem_ack_i;
    logic [DATA_W-1:0] dmem_rdata_i;
    logic              wb_valid_o;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [DATA_W-1:0] wdata_o;
    logic              err_o;

    typedef struct {
        logic [4:0]        wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic              err;
        logic              chk_data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .aluop_i      (aluop_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .err_o        (err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                            input logic err, input logic chk_data);
        wb_exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.err = err; e.chk_data = chk_data;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] sdata, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] wdata);
        in_valid = 1'b1; aluop_i = op; mem_addr_i = addr; store_data_i = sdata;
        wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Monitor: every writeback pulse must match the oldest expected bundle.
    always @(negedge clk) begin
        if (wb_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb_valid", 32'(wb_valid_o), 32'd0);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                check("wb_wd", 32'(wd_o), 32'(e.wd));
                check("wb_wreg", 32'(wreg_o), 32'(e.wreg));
                check("wb_err", 32'(err_o), 32'(e.err));
                if (e.chk_data) check("wb_wdata", wdata_o, e.wdata);
            end
        end else begin
            check("idle_wreg_forced0", 32'(wreg_o), 32'd0);
            check("idle_err", 32'(err_o), 32'd0);
        end
    end

    initial begin
        int req_cycles;
        int stall_cycles;
        rst = 1'b0; in_valid = 1'b0; aluop_i = '0; mem_addr_i = '0; store_data_i = '0;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_we", 32'(dmem_we_o), 32'd0);
        check("rst_daddr", 32'(dmem_addr_o), 32'd0);
        check("rst_wd_wdata", {27'd0, wd_o} | wdata_o, 32'd0);
        next_cycle(); rst = 1'b1;
        next_cycle();

        // ALU op passes straight through
        issue(EXE_ADD_OP, 10'h000, 32'h0, 5'd5, 1'b1, 32'h0000_0007);
        push_exp(5'd5, 1'b1, 32'h0000_0007, 1'b0, 1'b1);
        @(negedge clk); check("add_stall", 32'(stall_o), 32'd0);
        next_cycle(); in_valid = 1'b0;
        @(negedge clk); check("add_stall_after", 32'(stall_o), 32'd0);
        next_cycle();

        // LW, ack three cycles after req
        issue(EXE_LW_OP, 10'h010, 32'h0, 5'd3, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk); check("lw_accept_stall", 32'(stall_o), 32'd1);
        next_cycle(); in_valid = 1'b0;
        @(negedge clk);
        check("lw_daddr", 32'(dmem_addr_o), 32'h04);
        check("lw_we", 32'(dmem_we_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("lw_req_wait", 32'(dmem_req_o), 32'd1);
            check("lw_stall_wait", 32'(stall_o), 32'd1);
            next_cycle();
        end
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        push_exp(5'd3, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        @(negedge clk); check("lw_ack_stall", 32'(stall_o), 32'd0);
        next_cycle(); dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        @(negedge clk); check("lw_req_dropped", 32'(dmem_req_o), 32'd0);
        next_cycle();

        // SW at top word, ack in the first req cycle
        issue(EXE_SW_OP, 10'h3FC, 32'h1234_5678, 5'd0, 1'b0, 32'h0);
        @(negedge clk); check("sw_accept_stall", 32'(stall_o), 32'd1);
        next_cycle(); in_valid = 1'b0; dmem_ack_i = 1'b1;
        push_exp(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("sw_req", 32'(dmem_req_o), 32'd1);
        check("sw_we", 32'(dmem_we_o), 32'd1);
        check("sw_daddr", 32'(dmem_addr_o), 32'hFF);
        check("sw_wdata", dmem_wdata_o, 32'h1234_5678);
        check("sw_ack_stall", 32'(stall_o), 32'd0);
        next_cycle(); dmem_ack_i = 1'b0;
        next_cycle();

        // Misaligned LW: error pulse, no request
        issue(EXE_LW_OP, 10'h006, 32'h0, 5'd7, 1'b1, 32'h0);
        push_exp(5'd7, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk); check("mis_stall", 32'(stall_o), 32'd0);
        next_cycle(); in_valid = 1'b0;
        @(negedge clk); check("mis_req", 32'(dmem_req_o), 32'd0);
        next_cycle();

        // LW with no ack: timeout after TIMEOUT request cycles
        issue(EXE_LW_OP, 10'h020, 32'h0, 5'd4, 1'b1, 32'h0);
        push_exp(5'd4, 1'b0, 32'h0, 1'b1, 1'b0);
        next_cycle(); in_valid = 1'b0;
        req_cycles = 0; stall_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dmem_req_o) req_cycles++;
            if (dmem_req_o && stall_o) stall_cycles++;
        end
        check("to_req_cycles", 32'(req_cycles), 32'(TIMEOUT));
        check("to_stall_cycles", 32'(stall_cycles), 32'(TIMEOUT - 1));
        next_cycle(); dmem_ack_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk); check("late_ack_req", 32'(dmem_req_o), 32'd0);
        next_cycle(); dmem_ack_i = 1'b0;
        @(negedge clk); check("late_ack_no_wb", 32'(wb_valid_o), 32'd0);
        next_cycle();

        // Reset during the second BUSY cycle abandons the access
        issue(EXE_LW_OP, 10'h040, 32'h0, 5'd6, 1'b1, 32'h0);
        next_cycle(); in_valid = 1'b0;
        next_cycle(); rst = 1'b0;
        @(negedge clk); check("rst_busy_stall", 32'(stall_o), 32'd0);
        next_cycle(); rst = 1'b1;
        @(negedge clk);
        check("rst_busy_req", 32'(dmem_req_o), 32'd0);
        check("rst_busy_stall2", 32'(stall_o), 32'd0);
        check("rst_busy_no_wb", 32'(wb_valid_o), 32'd0);
        next_cycle();
        issue(EXE_ADD_OP, 10'h000, 32'h0, 5'd9, 1'b1, 32'h0000_00AB);
        push_exp(5'd9, 1'b1, 32'h0000_00AB, 1'b0, 1'b1);
        @(negedge clk); check("add2_stall", 32'(stall_o), 32'd0);
        next_cycle(); in_valid = 1'b0;
        repeat (3) next_cycle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory (MEM) pipeline stage that sits between the execute stage and writeback.
- Consumes the execute stage's `aluop`, effective address, store data and register-write bundle.
- Load/store ops run a multi-cycle req/ack transaction against the data memory and stall upstream until it completes.
- All other ops pass straight through to registered writeback outputs.

Parameters:
- ADDR_W, 10, width of effective/data-memory address (byte address).
- DATA_W, 32, data word width.
- TIMEOUT, 15, max BUSY cycles waiting for `dmem_ack_i` before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising `clk`).
- in_valid  in  1  execute-stage bundle valid.
- aluop_i  in  4  operation code from execute stage.
- mem_addr_i  in  ADDR_W  effective byte address (reg1 + sign-extended offset).
- store_data_i  in  DATA_W  store data (execute stage `reg2`).
- wd_i  in  5  destination register.
- wreg_i  in  1  register write enable from execute stage.
- wdata_i  in  DATA_W  ALU result.
- stall_o  out  1  upstream must hold its bundle while high.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  ADDR_W-2  word address.
- dmem_wdata_o  out  DATA_W  write data.
- dmem_ack_i  in  1  request completed.
- dmem_rdata_i  in  DATA_W  read data, valid when `dmem_ack_i` = 1.
- wb_valid_o  out  1  writeback bundle valid (1-cycle pulse per instruction).
- wd_o  out  5  writeback register.
- wreg_o  out  1  writeback enable.
- wdata_o  out  DATA_W  writeback data.
- err_o  out  1  1-cycle pulse: misaligned access or timeout.

Behaviour:
- Reset (rst = 0 at edge): state IDLE, timeout counter 0, and all outputs 0 (`stall_o` = 0 while in reset).
- is_mem = `aluop_i` is EXE_LW_OP or EXE_SW_OP. An access is misaligned when `mem_addr_i[1:0]` != 0.
- FSM states: IDLE and BUSY.
- IDLE, in_valid, !is_mem:
  - Next edge registers `wd_o` = `wd_i`, `wreg_o` = `wreg_i`, `wdata_o` = `wdata_i`, `wb_valid_o` = 1.
  - Latency 1; no stall.
- IDLE, in_valid, is_mem, misaligned:
  - Next edge gives `wb_valid_o` = 1, `wreg_o` = 0, `err_o` = 1.
  - No memory request, no stall.
- IDLE, in_valid, is_mem, aligned:
  - `stall_o` = 1 combinationally.
  - Latch op, `wd_i`, `wreg_i`, `mem_addr_i[ADDR_W-1:2]` and `store_data_i`; go to BUSY.
  - `dmem_req_o` is registered high from the next cycle.
- BUSY:
  - Hold `dmem_req_o` = 1 with `dmem_we_o`, `dmem_addr_o` and `dmem_wdata_o` stable until ack.
  - `stall_o` = !`dmem_ack_i` && !timeout_hit.
  - Counter increments each BUSY cycle without ack; timeout_hit = counter == TIMEOUT-1.
  - Inputs are ignored while BUSY.
- Ack sampled in BUSY: next edge goes to IDLE with `dmem_req_o` = 0 and `wb_valid_o` = 1.
  - LW: `wdata_o` = `dmem_rdata_i` (captured at the ack edge), `wreg_o` = latched `wreg_i`.
  - SW: `wreg_o` = 0.
- Timeout without ack: next edge goes to IDLE, `dmem_req_o` = 0, `wb_valid_o` = 1, `wreg_o` = 0, `err_o` = 1.
- Minimum load latency: accept at cycle t, req at t+1, ack at t+1, `wb_valid_o` at t+2.
- `wb_valid_o` and `err_o` are 1-cycle pulses. When `wb_valid_o` = 0, the wd/wreg/wdata outputs hold their last values but `wreg_o` is forced 0.
- `dmem_ack_i` seen in IDLE (stale/late) is ignored.
- Simultaneous ack and timeout_hit in the same cycle: ack wins.
- Reset while BUSY: abandon the transaction and drop `dmem_req_o` the next edge. The memory side tolerates an abandoned request.

Decomposition:
- Shared `defines.v`: EXE_LW_OP and EXE_SW_OP aluop codes (alongside the existing EXE_* ops), plus RstEnable-style macros for the active-low reset level.
- FSM state encodings are local.
- One sub-module is natural: `mem_timeout_ctr` (clear/enable/hit counter, TIMEOUT parameter).

Test Plan:
- EXE_ADD_OP, `wd_i` = 5, `wdata_i` = 0x0000_0007, `wreg_i` = 1 -> next cycle `wb_valid_o` = 1, `wd_o` = 5, `wdata_o` = 7, `wreg_o` = 1, `stall_o` never high.
- LW, `mem_addr_i` = 0x010, memory acks 3 cycles after req with 0xDEAD_BEEF -> `dmem_addr_o` = 0x04; `stall_o` high through the cycle before ack; `wdata_o` = 0xDEAD_BEEF, `wreg_o` = 1, one cycle after ack.
- SW, `mem_addr_i` = 0x3FC, `store_data_i` = 0x1234_5678, ack same cycle as req -> `dmem_we_o` = 1, `dmem_addr_o` = 0xFF, `dmem_wdata_o` = 0x1234_5678; `wb_valid_o` = 1 with `wreg_o` = 0 at accept+2.
- LW at `mem_addr_i` = 0x006 -> no `dmem_req_o`; next cycle `err_o` = 1, `wreg_o` = 0, `wb_valid_o` = 1.
- LW, ack never asserted -> `dmem_req_o` high exactly 15 cycles; then `err_o` = 1, `wreg_o` = 0, `stall_o` = 0; a late ack afterwards is ignored.
- rst = 0 in the 2nd BUSY cycle -> `dmem_req_o` = 0 and `stall_o` = 0 the next cycle; no `wb_valid_o` pulse; a following ADD completes normally.
